// File: rtl/irq_controller.sv
// Machine-level interrupt controller: mtime/mtimecmp timer, synchronised edge-detected external lines,
// fixed-priority arbitration and a request/ack/complete handshake allowing one trap in service at a time.
module irq_controller #(
   parameter int TIMER_W     = 32,
   parameter int N_EXT       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_EXT-1:0]           ext_inter,
   input  logic                       timer_en,
   input  logic                       counter_clear,
   input  logic                       cmp_wr,
   input  logic [TIMER_W-1:0]         cmp_wdata,
   input  logic                       mstatus_mie,
   input  logic                       mie_meie,
   input  logic                       mie_mtie,
   input  logic                       irq_ack,
   input  logic                       irq_complete,
   output logic                       irq_req,
   output logic [31:0]                irq_cause,
   output logic [$clog2(N_EXT)-1:0]   irq_src_id,
   output logic                       mip_meip,
   output logic                       mip_mtip,
   output logic [TIMER_W-1:0]         mtime
);

   // state      | meaning
   // ST_IDLE    | arbitrating; a winning source is latched and moves to ST_REQ
   // ST_REQ     | irq_req asserted, cause/src_id frozen, waiting for ack or mie drop
   // ST_SERVICE | trap in service, no new requests until irq_complete

   localparam int SRC_W = $clog2(N_EXT);
   localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
   localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t                               state_q, state_d;
   logic [SYNC_STAGES-1:0][N_EXT-1:0]    sync_q, sync_d;
   logic [N_EXT-1:0]                     dly_q, dly_d;
   logic [N_EXT-1:0]                     edge_q, edge_d;
   logic [N_EXT-1:0]                     pending_q, pending_d;
   logic [TIMER_W-1:0]                   mtime_q, mtime_d;
   logic [TIMER_W-1:0]                   mtimecmp_q, mtimecmp_d;
   logic [31:0]                          cause_q, cause_d;
   logic [SRC_W-1:0]                     src_q, src_d;

   logic             mtip;
   logic             ext_ok;
   logic             tim_ok;
   logic             ack_clr;
   logic [SRC_W-1:0] ext_win;

   // Edge is registered so a pending bit appears SYNC_STAGES+1 edges after the line is sampled.
   always_comb begin
      sync_d[0] = ext_inter;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      dly_d  = sync_q[SYNC_STAGES-1];
      edge_d = sync_q[SYNC_STAGES-1] & ~dly_q;
   end

   always_comb begin
      mtip    = (mtime_q >= mtimecmp_q);
      ext_ok  = mstatus_mie & mie_meie & (|pending_q);
      tim_ok  = mstatus_mie & mie_mtie & mtip;
      ext_win = '0;
      for (int i = N_EXT-1; i >= 0; i--) begin
         if (pending_q[i]) begin
            ext_win = SRC_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      src_d   = src_q;
      ack_clr = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ext_ok) begin
               state_d = ST_REQ;
               cause_d = CAUSE_MEI;
               src_d   = ext_win;
            end else if (tim_ok) begin
               state_d = ST_REQ;
               cause_d = CAUSE_MTI;
               src_d   = '0;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               state_d = ST_SERVICE;
               ack_clr = (cause_q == CAUSE_MEI);
            end else if (!mstatus_mie) begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVICE: begin
            if (irq_complete) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A fresh edge in the ack cycle re-sets the bit being cleared.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < N_EXT; i++) begin
         if (ack_clr && (src_q == SRC_W'(i))) begin
            pending_d[i] = 1'b0;
         end
      end
      pending_d = pending_d | edge_q;
   end

   always_comb begin
      mtime_d = mtime_q;
      if (counter_clear) begin
         mtime_d = '0;
      end else if (timer_en) begin
         mtime_d = mtime_q + 1'b1;
      end
      mtimecmp_d = cmp_wr ? cmp_wdata : mtimecmp_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         sync_q     <= '0;
         dly_q      <= '0;
         edge_q     <= '0;
         pending_q  <= '0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         cause_q    <= '0;
         src_q      <= '0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         dly_q      <= dly_d;
         edge_q     <= edge_d;
         pending_q  <= pending_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         cause_q    <= cause_d;
         src_q      <= src_d;
      end
   end

   assign irq_req    = (state_q == ST_REQ);
   assign irq_cause  = cause_q;
   assign irq_src_id = src_q;
   assign mip_meip   = |pending_q;
   assign mip_mtip   = mtip;
   assign mtime      = mtime_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios followed by random traffic, every cycle compared
// against a latency/rule-level reference model. Narrow timer so the wrap is reachable.
module tb_irq_controller;

   localparam int TW = 8;
   localparam int NE = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NE-1:0] ext_inter = '0;
   logic          timer_en = 1'b0;
   logic          counter_clear = 1'b0;
   logic          cmp_wr = 1'b0;
   logic [TW-1:0] cmp_wdata = '0;
   logic          mstatus_mie = 1'b0;
   logic          mie_meie = 1'b0;
   logic          mie_mtie = 1'b0;
   logic          irq_ack = 1'b0;
   logic          irq_complete = 1'b0;
   logic          irq_req;
   logic [31:0]   irq_cause;
   logic [1:0]    irq_src_id;
   logic          mip_meip;
   logic          mip_mtip;
   logic [TW-1:0] mtime;

   irq_controller #(.TIMER_W(TW), .N_EXT(NE), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .ext_inter(ext_inter), .timer_en(timer_en),
      .counter_clear(counter_clear), .cmp_wr(cmp_wr), .cmp_wdata(cmp_wdata),
      .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie),
      .irq_ack(irq_ack), .irq_complete(irq_complete), .irq_req(irq_req),
      .irq_cause(irq_cause), .irq_src_id(irq_src_id), .mip_meip(mip_meip),
      .mip_mtip(mip_mtip), .mtime(mtime)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a trap is either requested, in service, or neither.
   int unsigned m_time, m_cmp;
   bit          m_req, m_svc;
   bit [31:0]   m_cause;
   int          m_src;
   bit [NE-1:0] m_pend;
   bit [NE-1:0] h1, h2, h3, h4;   // raw line samples from 1..4 edges ago

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit          mtip, eok, tok;
      int          clr;
      bit [NE-1:0] newly;
      if (!rst) begin
         m_req = 0; m_svc = 0; m_cause = 0; m_src = 0; m_pend = '0;
         h1 = '0; h2 = '0; h3 = '0; h4 = '0;
         m_time = 0; m_cmp = (1 << TW) - 1;
      end else begin
         mtip = (m_time >= m_cmp);
         eok  = mstatus_mie && mie_meie && (m_pend != 0);
         tok  = mstatus_mie && mie_mtie && mtip;
         clr  = -1;
         if (!m_req && !m_svc) begin
            if (eok) begin
               m_req = 1; m_cause = 32'h8000_000B;
               m_src = -1;
               for (int i = 0; i < NE; i++) if (m_pend[i] && m_src < 0) m_src = i;
            end else if (tok) begin
               m_req = 1; m_cause = 32'h8000_0007; m_src = 0;
            end
         end else if (m_req) begin
            if (irq_ack) begin
               m_req = 0; m_svc = 1;
               if (m_cause == 32'h8000_000B) clr = m_src;
            end else if (!mstatus_mie) begin
               m_req = 0;
            end
         end else if (irq_complete) begin
            m_svc = 0;
         end
         // A line sampled high after being low three edges earlier becomes pending now.
         newly = h3 & ~h4;
         if (clr >= 0) m_pend[clr] = 1'b0;
         m_pend = m_pend | newly;
         h4 = h3; h3 = h2; h2 = h1; h1 = ext_inter;
         if (counter_clear) m_time = 0;
         else if (timer_en) m_time = (m_time + 1) % (1 << TW);
         if (cmp_wr) m_cmp = cmp_wdata;
      end
   endtask

   task automatic check_all();
      chk("irq_req",    irq_req,    m_req);
      chk("irq_cause",  irq_cause,  m_cause);
      chk("irq_src_id", irq_src_id, m_src);
      chk("mip_meip",   mip_meip,   (m_pend != 0));
      chk("mip_mtip",   mip_mtip,   (m_time >= m_cmp));
      chk("mtime",      mtime,      m_time);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1; step(); irq_ack = 1'b0;
   endtask

   task automatic pulse_complete();
      irq_complete = 1'b1; step(); irq_complete = 1'b0;
   endtask

   initial begin
      // Reset with inputs toggling
      for (int i = 0; i < 2; i++) begin
         ext_inter = 4'($urandom);
         timer_en  = ~timer_en;
         step();
      end
      chk("rst_req", irq_req, 1'b0);
      chk("rst_cause", irq_cause, 32'h0);
      chk("rst_mtime", mtime, '0);
      chk("rst_mtip", mip_mtip, 1'b0);
      rst = 1'b1; ext_inter = '0; timer_en = 1'b0;
      repeat (4) step();

      // Timer request, service, re-request while mtip stays high
      cmp_wr = 1'b1; cmp_wdata = 8'd10; counter_clear = 1'b1;
      mstatus_mie = 1'b1; mie_mtie = 1'b1;
      step();
      cmp_wr = 1'b0; counter_clear = 1'b0; timer_en = 1'b1;
      repeat (10) step();
      chk("tmr_mtime10", mtime, 8'd10);
      chk("tmr_req_early", irq_req, 1'b0);
      step();
      chk("tmr_req", irq_req, 1'b1);
      chk("tmr_cause", irq_cause, 32'h8000_0007);
      pulse_ack();
      chk("tmr_ack_req", irq_req, 1'b0);
      step();
      pulse_complete();
      step();
      chk("tmr_rereq", irq_req, 1'b1);
      pulse_ack();
      mie_mtie = 1'b0; timer_en = 1'b0;
      pulse_complete();
      step();

      // External line 2: request four edges after the sampled rise
      mie_meie = 1'b1; ext_inter = 4'b0100;
      step();
      step(); step();
      chk("ext_meip_early", mip_meip, 1'b0);
      step();
      chk("ext_meip", mip_meip, 1'b1);
      chk("ext_req_early", irq_req, 1'b0);
      step();
      chk("ext_req", irq_req, 1'b1);
      chk("ext_cause", irq_cause, 32'h8000_000B);
      chk("ext_src", irq_src_id, 2'd2);
      ext_inter = '0;
      pulse_ack();
      chk("ext_ack_meip", mip_meip, 1'b0);
      pulse_complete();
      step();

      // Priority: lines 3 and 1 plus timer all pending
      mstatus_mie = 1'b0; ext_inter = 4'b1010;
      step();
      ext_inter = '0;
      repeat (4) step();
      mie_mtie = 1'b1;
      chk("pri_mtip", mip_mtip, 1'b1);
      mstatus_mie = 1'b1;
      step();
      chk("pri_src1", irq_src_id, 2'd1);
      chk("pri_cause1", irq_cause, 32'h8000_000B);
      pulse_ack(); pulse_complete(); step();
      chk("pri_src3", irq_src_id, 2'd3);
      pulse_ack(); pulse_complete(); step();
      chk("pri_timer", irq_cause, 32'h8000_0007);
      chk("pri_timer_req", irq_req, 1'b1);
      mie_mtie = 1'b0;
      pulse_ack(); pulse_complete(); step();

      // Withdraw on mie drop, then ack colliding with mie drop
      ext_inter = 4'b0001;
      step();
      ext_inter = '0;
      repeat (4) step();
      chk("wd_req", irq_req, 1'b1);
      mstatus_mie = 1'b0;
      step();
      chk("wd_withdrawn", irq_req, 1'b0);
      chk("wd_pend_kept", mip_meip, 1'b1);
      mstatus_mie = 1'b1;
      step();
      chk("wd_rereq", irq_req, 1'b1);
      irq_ack = 1'b1; mstatus_mie = 1'b0;
      step();
      irq_ack = 1'b0; mstatus_mie = 1'b1;
      chk("col_ack_wins", irq_req, 1'b0);
      chk("col_ack_clr", mip_meip, 1'b0);
      pulse_complete();
      step();

      // New edge on the acked line landing in the ack cycle
      ext_inter = 4'b0001;
      step();
      ext_inter = '0;
      repeat (4) step();
      chk("col2_req", irq_req, 1'b1);
      ext_inter = 4'b0001;
      step();
      ext_inter = '0;
      step(); step();
      pulse_ack();
      chk("col_edge_wins", mip_meip, 1'b1);
      pulse_complete();
      step();
      chk("col_rereq", irq_req, 1'b1);
      pulse_ack(); pulse_complete(); step();

      // Wrap and clear
      cmp_wr = 1'b1; cmp_wdata = 8'hFF; counter_clear = 1'b1;
      step();
      cmp_wr = 1'b0; counter_clear = 1'b0; timer_en = 1'b1;
      repeat (255) step();
      chk("wrap_max", mtime, 8'hFF);
      chk("wrap_mtip", mip_mtip, 1'b1);
      step();
      chk("wrap_zero", mtime, 8'h00);
      repeat (5) step();
      counter_clear = 1'b1;
      step();
      counter_clear = 1'b0;
      chk("clr_over_inc", mtime, 8'h00);

      // Reset while a trap is in service
      timer_en = 1'b0; cmp_wr = 1'b1; cmp_wdata = 8'h00; mie_mtie = 1'b1;
      step();
      cmp_wr = 1'b0;
      step();
      chk("rsv_req", irq_req, 1'b1);
      pulse_ack();
      rst = 1'b0;
      step();
      rst = 1'b1; mie_mtie = 1'b0;
      chk("rsv_req0", irq_req, 1'b0);
      chk("rsv_cause0", irq_cause, 32'h0);
      chk("rsv_mtip0", mip_mtip, 1'b0);
      step();

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 3) == 0) ext_inter = ext_inter ^ 4'(1 << $urandom_range(0, 3));
         timer_en      = ($urandom_range(0, 3) != 0);
         counter_clear = ($urandom_range(0, 39) == 0);
         cmp_wr        = ($urandom_range(0, 19) == 0);
         cmp_wdata     = 8'($urandom);
         if ($urandom_range(0, 9) == 0) mstatus_mie = ~mstatus_mie;
         if ($urandom_range(0, 15) == 0) mie_meie = ~mie_meie;
         if ($urandom_range(0, 15) == 0) mie_mtie = ~mie_mtie;
         irq_ack      = ($urandom_range(0, 3) == 0);
         irq_complete = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
